lcd_refresh_ctrl: RTL and testbench
===================================

# lcd_refresh_ctrl

Sequencer that owns the read port of the 32x8 character RAM and continuously mirrors its contents onto the board's 16x2 HD44780-compatible LCD over the 4-bit interface. After reset it runs the LCD power-up/initialisation sequence. It then loops forever: RAM bytes 0–15 go to line 1 and bytes 16–31 go to line 2. It sits between the character RAM, which the I2C slave writes, and the LCD pins, and it needs no handshake with the writer side.

## Interface
Parameters (cycle counts; defaults are for a 50 MHz clock, and benches shrink them):
- T_PWRUP, 750000: wait after reset before the first nibble (15 ms).
- T_INIT1, 205000: wait after init nibble 1 (4.1 ms).
- T_INIT2, 5000: wait after init nibble 2 (100 µs).
- T_SU, 2: RS/data setup before E rises.
- T_EH, 12: E high width.
- T_NIB, 50: gap between the high and low nibbles of a byte (1 µs).
- T_CMD, 2000: wait after each byte, and after init nibbles 3 and 4 (40 µs).
- T_CLR, 82000: wait after the Clear Display command (1.64 ms).

Ports:
- clk, in, 1: system clock; every output is driven from a register.
- rst_n, in, 1: synchronous reset, active-low, sampled on posedge clk.
- RADD, out, 5: RAM read address.
- DOUT, in, 8: RAM read data, combinational from RADD.
- LCD_E, out, 1: LCD enable strobe.
- LCD_RS, out, 1: LCD register select; 0 = command, 1 = data.
- LCD_RW, out, 1: LCD read/write select; held at 0 (write only).
- LCD_D, out, 4: LCD data nibble.
- INIT_DONE, out, 1: goes high once initialisation completes and stays high until reset.
- FRAME_DONE, out, 1: one-cycle pulse after character 31 finishes its T_CMD wait.

## Operation
- Reset values: RADD=0, LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_D=0, INIT_DONE=0, FRAME_DONE=0. The top FSM returns to PWRUP. If rst_n is asserted mid-strobe, LCD_E drops on the next edge and the full power-up sequence restarts.
- Top FSM states: PWRUP → INIT_NIB → CONFIG → CLEAR → LINE_ADDR → FETCH → SEND → NEXT.
  - PWRUP: wait T_PWRUP.
  - INIT_NIB: four nibble-only writes with RS=0. Data and following waits:
    - 0x3, then T_INIT1.
    - 0x3, then T_INIT2.
    - 0x3, then T_CMD.
    - 0x2, then T_CMD.
  - CONFIG: send three command bytes, each followed by T_CMD:
    - 0x28 (4-bit, 2 lines).
    - 0x06 (increment, no shift).
    - 0x0C (display on, cursor off).
  - CLEAR: send 0x01, then wait T_CLR. INIT_DONE is set at the end of this wait.
  - LINE_ADDR: send 0x80 when idx=0, or 0xC0 when idx=16, with RS=0.
  - FETCH: RADD is already equal to idx. Latch DOUT into the char register on this edge.
  - SEND: send the char register with RS=1.
  - NEXT: idx increments, wrapping from 31 to 0. When the old idx was 31, pulse FRAME_DONE. Next state is LINE_ADDR if the new idx is 0 or 16, otherwise FETCH.
- Byte send: high nibble, then T_NIB, then low nibble, then T_CMD. Nibble-only sends skip the low nibble.
- Nibble strobe:
  - LCD_RS and LCD_D are set.
  - After T_SU cycles, LCD_E rises.
  - LCD_E stays high for T_EH cycles, then falls.
  - LCD_RS and LCD_D are held at least 1 cycle after E falls.
- RAM coherency: each character is sampled exactly once per frame, in FETCH, so the two nibbles of a character never come from different bytes. A write to RAM[k] landing after k's FETCH appears on the next frame.
- Counters: a single delay counter wide enough for T_PWRUP (20 bits at the defaults) is loaded with the target count and decremented to 0. A delay parameter of 0 is treated as 1 cycle.

## Timing
- Byte cost, in cycles: 2·(T_SU+T_EH+1) + T_NIB + T_CMD, ±1 for state transitions.
- Frame = 32 data bytes + 2 address bytes + 32 FETCH cycles + 32 NEXT cycles.
- RADD changes only in NEXT, so DOUT has a full cycle to settle before FETCH.
- FRAME_DONE lasts exactly one cycle per frame.
- LCD_E never rises while LCD_RS or LCD_D is changing.
- LCD_E is never high for a cycle count other than T_EH.

## Structure
- Shared package (lcd_pkg) holds:
  - Command constants: LCD_FUNC_SET=0x28, LCD_ENTRY=0x06, LCD_DISP_ON=0x0C, LCD_CLEAR=0x01, LCD_LINE1=0x80, LCD_LINE2=0xC0.
  - The top-FSM state encoding.
- Sub-module lcd_nibble_writer:
  - Inputs: start, rs, byte, nibble_only, plus the wait count to apply after the byte.
  - Output: done.
  - Owns LCD_E, LCD_RS and LCD_D, the setup/hold/gap timing, and the post-byte wait.
  - done is a one-cycle pulse. start is ignored while the writer is busy.

## Test plan
Benches shrink the parameters to: T_PWRUP=20, T_INIT1=10, T_INIT2=5, T_SU=2, T_EH=3, T_NIB=4, T_CMD=6, T_CLR=8.
1. Reset, then run. Required response:
   - Init strobes carry D = 3, 3, 3, 2 (RS=0).
   - Then bytes 0x28, 0x06, 0x0C, 0x01 as nibble pairs 2/8, 0/6, 0/C, 0/1.
   - INIT_DONE rises after the T_CLR wait.
2. RAM preloaded with 0x41+i. Required response:
   - First frame strobes 0x80, then 'A'..'P' with RS=1.
   - Then 0xC0, then 0x51..0x60.
   - FRAME_DONE pulses once, and the next frame restarts at 0x80.
3. Write RAM[5]=0x7E in the same cycle as idx 5's FETCH → the old value is shown this frame and 0x7E next frame. Both nibbles of each character always come from the same byte.
4. Assert rst_n low while LCD_E is high during frame 1 → the next cycle shows E=0 and all outputs at their reset values. The sequence restarts at PWRUP, and INIT_DONE stays 0 until init completes again.
5. Timing checker active across two full frames → every E-high lasts exactly T_EH cycles, RS/D are stable from T_SU before E rises until 1 cycle after it falls, and LCD_RW stays 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-RAM-to-LCD refresh sequencer.
// Holds the HD44780 command bytes, both FSM state encodings, and small
// constant helpers used to size and load the delay counters.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no display shift
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LCD_LINE2    = 8'hC0;  // DDRAM address 0x40

    // Power-up nibbles: three "8-bit mode" wakeups, then switch to 4-bit.
    localparam logic [3:0] INIT_WAKE    = 4'h3;
    localparam logic [3:0] INIT_4BIT    = 4'h2;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT_NIB,
        ST_CONFIG,
        ST_CLEAR,
        ST_LINE_ADDR,
        ST_FETCH,
        ST_SEND,
        ST_NEXT
    } top_state_t;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_SETUP,
        WR_EHIGH,
        WR_GAP,
        WR_WAIT
    } wr_state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counters are loaded with (cycles - 1), so they only need to hold max-1.
    function automatic int cnt_width(input int max_val);
        return (max_val < 3) ? 1 : $clog2(max_val);
    endfunction

    // Load value for an N-cycle interval; a delay of 0 still lasts 1 cycle.
    function automatic int cycles_m1(input int t);
        return (t < 1) ? 0 : t - 1;
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one byte (or a lone high nibble) onto the 4-bit HD44780 bus.
// Sequence: present RS/D, wait T_SU, E high for T_EH, then either the
// T_NIB gap and the low nibble, or straight into the post-byte wait.
// RS/D are only changed when entering SETUP, so they are held through the
// whole E pulse and for at least one cycle after E falls.
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   start           begin a transfer (ignored unless idle)
//   rs, char_byte   register select and byte to send
//   nibble_only     send only char_byte[7:4]
//   wait_m1         post-transfer wait length minus one
//   done            one-cycle pulse once the post-transfer wait has elapsed
//   lcd_e/rs/d      registered LCD pins
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int T_SU  = 2,
    parameter int T_EH  = 12,
    parameter int T_NIB = 50,
    parameter int CW    = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          rs,
    input  logic [7:0]    char_byte,
    input  logic          nibble_only,
    input  logic [CW-1:0] wait_m1,
    output logic          done,
    output logic          lcd_e,
    output logic          lcd_rs,
    output logic [3:0]    lcd_d
);

    localparam logic [CW-1:0] SU_M1  = CW'(cycles_m1(T_SU));
    localparam logic [CW-1:0] EH_M1  = CW'(cycles_m1(T_EH));
    localparam logic [CW-1:0] NIB_M1 = CW'(cycles_m1(T_NIB));
    localparam logic [CW-1:0] ONE    = CW'(1);

    wr_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] wait_reg, wait_next;
    logic [7:0]    byte_reg, byte_next;
    logic          nib_only_reg, nib_only_next;
    logic          low_reg, low_next;     // 1 while the low nibble is on the bus
    logic          e_reg, e_next;
    logic          rs_reg, rs_next;
    logic [3:0]    d_reg, d_next;
    logic          done_reg, done_next;
    logic          cnt_zero;

    assign cnt_zero = (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= WR_IDLE;
            cnt_reg      <= '0;
            wait_reg     <= '0;
            byte_reg     <= 8'h00;
            nib_only_reg <= 1'b0;
            low_reg      <= 1'b0;
            e_reg        <= 1'b0;
            rs_reg       <= 1'b0;
            d_reg        <= 4'h0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            wait_reg     <= wait_next;
            byte_reg     <= byte_next;
            nib_only_reg <= nib_only_next;
            low_reg      <= low_next;
            e_reg        <= e_next;
            rs_reg       <= rs_next;
            d_reg        <= d_next;
            done_reg     <= done_next;
        end
    end

    // Next state and interval counter.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_zero ? cnt_reg : cnt_reg - ONE;
        unique case (state_reg)
            WR_IDLE: begin
                cnt_next = cnt_reg;
                if (start) begin
                    state_next = WR_SETUP;
                    cnt_next   = SU_M1;
                end
            end
            WR_SETUP: begin
                if (cnt_zero) begin
                    state_next = WR_EHIGH;
                    cnt_next   = EH_M1;
                end
            end
            WR_EHIGH: begin
                if (cnt_zero) begin
                    if (!low_reg && !nib_only_reg) begin
                        state_next = WR_GAP;
                        cnt_next   = NIB_M1;
                    end else begin
                        state_next = WR_WAIT;
                        cnt_next   = wait_reg;
                    end
                end
            end
            WR_GAP: begin
                if (cnt_zero) begin
                    state_next = WR_SETUP;
                    cnt_next   = SU_M1;
                end
            end
            WR_WAIT: begin
                if (cnt_zero) begin
                    state_next = WR_IDLE;
                end
            end
            default: state_next = WR_IDLE;
        endcase
    end

    // Registered outputs and transfer operands.
    always_comb begin
        e_next        = (state_next == WR_EHIGH);
        done_next     = (state_reg == WR_WAIT) && cnt_zero;
        rs_next       = rs_reg;
        d_next        = d_reg;
        low_next      = low_reg;
        byte_next     = byte_reg;
        nib_only_next = nib_only_reg;
        wait_next     = wait_reg;
        if (state_reg == WR_IDLE && start) begin
            rs_next       = rs;
            d_next        = char_byte[7:4];
            low_next      = 1'b0;
            byte_next     = char_byte;
            nib_only_next = nibble_only;
            wait_next     = wait_m1;
        end else if (state_reg == WR_GAP && cnt_zero) begin
            d_next   = byte_reg[3:0];
            low_next = 1'b1;
        end
    end

    assign done   = done_reg;
    assign lcd_e  = e_reg;
    assign lcd_rs = rs_reg;
    assign lcd_d  = d_reg;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Owns the character RAM read port and continuously mirrors the 32 bytes
// onto a 16x2 HD44780 LCD: bytes 0-15 on line 1, 16-31 on line 2. Runs the
// power-up/initialisation sequence once after reset, then refreshes forever.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   RADD, DOUT   RAM read address / combinational read data
//   LCD_E, LCD_RS, LCD_RW, LCD_D   LCD pins (RW tied to write)
//   INIT_DONE    high from end of the clear-display wait until reset
//   FRAME_DONE   one-cycle pulse after character 31 completes
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_INIT1 = 205000,
    parameter int T_INIT2 = 5000,
    parameter int T_SU    = 2,
    parameter int T_EH    = 12,
    parameter int T_NIB   = 50,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [4:0] RADD,
    input  logic [7:0] DOUT,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [3:0] LCD_D,
    output logic       INIT_DONE,
    output logic       FRAME_DONE
);

    localparam int CW = cnt_width(imax(imax(imax(T_PWRUP, T_INIT1), imax(T_INIT2, T_SU)),
                                       imax(imax(T_EH, T_NIB), imax(T_CMD, T_CLR))));
    localparam logic [CW-1:0] PWRUP_M1 = CW'(cycles_m1(T_PWRUP));
    localparam logic [CW-1:0] INIT1_M1 = CW'(cycles_m1(T_INIT1));
    localparam logic [CW-1:0] INIT2_M1 = CW'(cycles_m1(T_INIT2));
    localparam logic [CW-1:0] CMD_M1   = CW'(cycles_m1(T_CMD));
    localparam logic [CW-1:0] CLR_M1   = CW'(cycles_m1(T_CLR));
    localparam logic [CW-1:0] ONE      = CW'(1);

    top_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [1:0]    step_reg;         // position within INIT_NIB / CONFIG lists
    logic          issued_reg;       // a writer transfer is in flight
    logic [4:0]    idx_reg;
    logic [4:0]    idx_inc;
    logic [7:0]    char_reg;
    logic          init_done_reg;
    logic          frame_done_reg;

    logic          wr_start;
    logic          wr_rs;
    logic [7:0]    wr_byte;
    logic          wr_nib_only;
    logic [CW-1:0] wr_wait_m1;
    logic          wr_done;

    assign idx_inc = idx_reg + 5'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_PWRUP;
            cnt_reg        <= PWRUP_M1;
            step_reg       <= 2'd0;
            issued_reg     <= 1'b0;
            idx_reg        <= 5'd0;
            char_reg       <= 8'h00;
            init_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_PWRUP && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - ONE;
            end
            if (wr_start) begin
                issued_reg <= 1'b1;
            end else if (wr_done) begin
                issued_reg <= 1'b0;
            end
            if (wr_done) begin
                step_reg <= (state_next != state_reg) ? 2'd0 : step_reg + 2'd1;
            end
            // The only RAM sample of this character for the frame.
            if (state_reg == ST_FETCH) begin
                char_reg <= DOUT;
            end
            // RADD follows idx, so it only moves here and DOUT settles a
            // full cycle before the next FETCH.
            if (state_reg == ST_NEXT) begin
                idx_reg <= idx_inc;
            end
            frame_done_reg <= (state_reg == ST_NEXT) && (idx_reg == 5'd31);
            if (state_reg == ST_CLEAR && wr_done) begin
                init_done_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_PWRUP:     if (cnt_reg == '0) state_next = ST_INIT_NIB;
            ST_INIT_NIB:  if (wr_done && step_reg == 2'd3) state_next = ST_CONFIG;
            ST_CONFIG:    if (wr_done && step_reg == 2'd2) state_next = ST_CLEAR;
            ST_CLEAR:     if (wr_done) state_next = ST_LINE_ADDR;
            ST_LINE_ADDR: if (wr_done) state_next = ST_FETCH;
            ST_FETCH:     state_next = ST_SEND;
            ST_SEND:      if (wr_done) state_next = ST_NEXT;
            ST_NEXT:      state_next = (idx_inc[3:0] == 4'd0) ? ST_LINE_ADDR : ST_FETCH;
            default:      state_next = ST_PWRUP;
        endcase
    end

    // Writer command for the current state; one transfer per issue.
    always_comb begin
        wr_start    = 1'b0;
        wr_rs       = 1'b0;
        wr_byte     = 8'h00;
        wr_nib_only = 1'b0;
        wr_wait_m1  = CMD_M1;
        unique case (state_reg)
            ST_INIT_NIB: begin
                wr_start    = !issued_reg;
                wr_nib_only = 1'b1;
                wr_byte     = {(step_reg == 2'd3) ? INIT_4BIT : INIT_WAKE, 4'h0};
                case (step_reg)
                    2'd0:    wr_wait_m1 = INIT1_M1;
                    2'd1:    wr_wait_m1 = INIT2_M1;
                    default: wr_wait_m1 = CMD_M1;
                endcase
            end
            ST_CONFIG: begin
                wr_start = !issued_reg;
                case (step_reg)
                    2'd0:    wr_byte = LCD_FUNC_SET;
                    2'd1:    wr_byte = LCD_ENTRY;
                    default: wr_byte = LCD_DISP_ON;
                endcase
            end
            ST_CLEAR: begin
                wr_start   = !issued_reg;
                wr_byte    = LCD_CLEAR;
                wr_wait_m1 = CLR_M1;
            end
            ST_LINE_ADDR: begin
                wr_start = !issued_reg;
                wr_byte  = idx_reg[4] ? LCD_LINE2 : LCD_LINE1;
            end
            ST_SEND: begin
                wr_start = !issued_reg;
                wr_rs    = 1'b1;
                wr_byte  = char_reg;
            end
            default: ;
        endcase
    end

    lcd_nibble_writer #(
        .T_SU  (T_SU),
        .T_EH  (T_EH),
        .T_NIB (T_NIB),
        .CW    (CW)
    ) u_writer (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (wr_start),
        .rs          (wr_rs),
        .char_byte   (wr_byte),
        .nibble_only (wr_nib_only),
        .wait_m1     (wr_wait_m1),
        .done        (wr_done),
        .lcd_e       (LCD_E),
        .lcd_rs      (LCD_RS),
        .lcd_d       (LCD_D)
    );

    assign RADD       = idx_reg;
    assign LCD_RW     = 1'b0;
    assign INIT_DONE  = init_done_reg;
    assign FRAME_DONE = frame_done_reg;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Scoreboard bench for lcd_refresh_ctrl: the stimulus side pushes the
// expected {RS,D} of every E strobe (built from the LCD protocol and the
// RAM image), and a monitor pops one entry per rising E while also checking
// strobe timing, INIT_DONE and FRAME_DONE behaviour.
module tb_lcd_refresh_ctrl;

    localparam int T_PWRUP = 20;
    localparam int T_INIT1 = 10;
    localparam int T_INIT2 = 5;
    localparam int T_SU    = 2;
    localparam int T_EH    = 3;
    localparam int T_NIB   = 4;
    localparam int T_CMD   = 6;
    localparam int T_CLR   = 8;

    logic       clk;
    logic       rst_n;
    logic [4:0] RADD;
    logic [7:0] DOUT;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [3:0] LCD_D;
    logic       INIT_DONE;
    logic       FRAME_DONE;

    logic [7:0] ram [0:31];
    logic [7:0] img [0:31];
    logic [4:0] exp_q [$];
    int         checks;
    int         failures;

    assign DOUT = ram[RADD];

    lcd_refresh_ctrl #(
        .T_PWRUP (T_PWRUP),
        .T_INIT1 (T_INIT1),
        .T_INIT2 (T_INIT2),
        .T_SU    (T_SU),
        .T_EH    (T_EH),
        .T_NIB   (T_NIB),
        .T_CMD   (T_CMD),
        .T_CLR   (T_CLR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RADD       (RADD),
        .DOUT       (DOUT),
        .LCD_E      (LCD_E),
        .LCD_RS     (LCD_RS),
        .LCD_RW     (LCD_RW),
        .LCD_D      (LCD_D),
        .INIT_DONE  (INIT_DONE),
        .FRAME_DONE (FRAME_DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected-traffic model: what the LCD must see, by protocol rule.
    function automatic void push_byte(input logic rs, input logic [7:0] b);
        exp_q.push_back({rs, b[7:4]});
        exp_q.push_back({rs, b[3:0]});
    endfunction

    function automatic void push_init();
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h03);
        exp_q.push_back(5'h02);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h01);
    endfunction

    function automatic void push_frame(input logic [7:0] pic [0:31]);
        push_byte(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) push_byte(1'b1, pic[i]);
        push_byte(1'b0, 8'hC0);
        for (int i = 16; i < 32; i++) push_byte(1'b1, pic[i]);
    endfunction

    // sel: 0 INIT_DONE high, 1 FRAME_DONE high, 2 RADD==5, 3 LCD_E high
    task automatic wait_for(input int sel, input int budget);
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = (INIT_DONE === 1'b1);
                1:       hit = (FRAME_DONE === 1'b1);
                2:       hit = (RADD === 5'd5);
                default: hit = (LCD_E === 1'b1);
            endcase
        end
        chk($sformatf("wait_sel%0d", sel), 32'(hit), 32'd1);
    endtask

    // Monitor: scoreboard pop on each E rise plus timing rules.
    initial begin
        int         strobes;
        int         frame_strobes;
        int         e_cnt;
        int         stable;
        logic       e_prev;
        logic       id_prev;
        logic       fd_prev;
        logic [4:0] prev_rsd;
        logic [4:0] expv;
        logic       changed;
        strobes = 0; frame_strobes = 0; e_cnt = 0; stable = 0;
        e_prev = 1'b0; id_prev = 1'b0; fd_prev = 1'b0; prev_rsd = 5'd0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                strobes = 0; frame_strobes = 0; e_cnt = 0; stable = 0;
                e_prev = 1'b0; id_prev = 1'b0; fd_prev = 1'b0; prev_rsd = 5'd0;
                continue;
            end
            changed = ({LCD_RS, LCD_D} !== prev_rsd);
            stable  = changed ? 0 : stable + 1;
            if (LCD_E && !e_prev) begin
                strobes++;
                frame_strobes++;
                chk("setup_time", 32'(stable >= T_SU), 32'd1);
                chk("rw_low", 32'(LCD_RW), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'({LCD_RS, LCD_D}), 32'h1F);
                end else begin
                    expv = exp_q.pop_front();
                    $display("strobe %0d: rs=%0b d=%h want rs=%0b d=%h",
                             strobes, LCD_RS, LCD_D, expv[4], expv[3:0]);
                    chk("strobe_rs_d", 32'({LCD_RS, LCD_D}), 32'(expv));
                end
            end
            if (LCD_E && e_prev) chk("stable_while_e", 32'(changed), 32'd0);
            if (!LCD_E && e_prev) begin
                chk("e_width", 32'(e_cnt), 32'(T_EH));
                chk("hold_after_e", 32'(changed), 32'd0);
            end
            e_cnt = LCD_E ? e_cnt + 1 : 0;
            if (INIT_DONE && !id_prev) begin
                chk("init_strobes", 32'(strobes), 32'd12);
                frame_strobes = 0;
            end
            if (!INIT_DONE && id_prev) chk("init_done_sticky", 32'(INIT_DONE), 32'd1);
            if (FRAME_DONE) begin
                chk("frame_done_width", 32'(fd_prev), 32'd0);
                chk("frame_strobes", 32'(frame_strobes), 32'd68);
                frame_strobes = 0;
            end
            e_prev   = LCD_E;
            id_prev  = INIT_DONE;
            fd_prev  = FRAME_DONE;
            prev_rsd = {LCD_RS, LCD_D};
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 32; i++) ram[i] = 8'(8'h41 + i);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({RADD, LCD_E, LCD_RS, LCD_RW, LCD_D, INIT_DONE, FRAME_DONE}), 32'd0);
        push_init();
        push_frame(ram);
        rst_n = 1'b1;

        // Reset in the middle of an E pulse during frame 1.
        wait_for(0, 3000);
        repeat ($urandom_range(20, 400)) @(negedge clk);
        wait_for(3, 200);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_e", 32'(LCD_E), 32'd0);
        chk("midreset_outputs", 32'({RADD, LCD_RS, LCD_RW, LCD_D, INIT_DONE, FRAME_DONE}), 32'd0);
        @(negedge clk);
        exp_q.delete();
        push_init();
        push_frame(ram);
        rst_n = 1'b1;

        // Frame 1 keeps the old RAM[5]; the write lands on idx 5's FETCH edge.
        wait_for(0, 3000);
        wait_for(2, 3000);
        @(posedge clk);
        ram[5] <= 8'h7E;
        wait_for(1, 3000);
        push_frame(ram);

        // Random RAM images applied at frame boundaries.
        for (int f = 0; f < 2; f++) begin
            wait_for(1, 3000);
            for (int i = 0; i < 32; i++) img[i] = 8'($urandom_range(0, 255));
            push_frame(img);
            @(posedge clk);
            for (int i = 0; i < 32; i++) ram[i] <= img[i];
        end
        wait_for(1, 3000);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
